// File: rtl/xu0_bcd_wbq_if.sv
// xu0_bcd_wbq_if
// Bundles the BCD write-back queue signals: EX1 issue tag, EX3 datapath result,
// per-thread flush, decode stall, GPR write request/grant and the error flag.
//   master : decode / BCD datapath / GPR arbiter side (drives issue, result, flush, grant)
//   slave  : the write-back queue (drives stall, write request, error)
interface xu0_bcd_wbq_if #(
    parameter int THREADS   = 2,
    parameter int GPR_WIDTH = 64
);
    localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1;

    logic                 dec_bcd_ex1_val;
    logic [TW-1:0]        dec_bcd_ex1_tid;
    logic [5:0]           dec_bcd_ex1_ta;
    logic                 bcd_byp_ex3_done;
    logic [GPR_WIDTH-1:0] bcd_byp_ex3_rt;
    logic [THREADS-1:0]   xu_ex_flush;
    logic                 bcd_dec_stall;
    logic                 bcd_wr_val;
    logic [TW-1:0]        bcd_wr_tid;
    logic [5:0]           bcd_wr_ta;
    logic [GPR_WIDTH-1:0] bcd_wr_data;
    logic                 gpr_bcd_wr_gnt;
    logic                 bcd_wbq_err;

    modport master (
        output dec_bcd_ex1_val, dec_bcd_ex1_tid, dec_bcd_ex1_ta,
        output bcd_byp_ex3_done, bcd_byp_ex3_rt, xu_ex_flush, gpr_bcd_wr_gnt,
        input  bcd_dec_stall, bcd_wr_val, bcd_wr_tid, bcd_wr_ta, bcd_wr_data, bcd_wbq_err
    );

    modport slave (
        input  dec_bcd_ex1_val, dec_bcd_ex1_tid, dec_bcd_ex1_ta,
        input  bcd_byp_ex3_done, bcd_byp_ex3_rt, xu_ex_flush, gpr_bcd_wr_gnt,
        output bcd_dec_stall, bcd_wr_val, bcd_wr_tid, bcd_wr_ta, bcd_wr_data, bcd_wbq_err
    );
endinterface

// File: rtl/xu0_bcd_wbq.sv
// xu0_bcd_wbq
// BCD result write-back queue. Carries the {tid,ta} tag of each BCD op from EX1
// through EX2/EX3 alongside the BCD datapath, captures the EX3 result into a
// DEPTH-entry FIFO and drains it to the shared GPR write port on valid/grant.
// Ports:
//   clk_i-style scalars : clk (rising edge), rst (synchronous, active high)
//   bus (slave)         : issue tag, EX3 result, per-thread flush, decode stall,
//                         GPR write request/grant, sticky protocol error
module xu0_bcd_wbq #(
    parameter int THREADS   = 2,
    parameter int DEPTH     = 4,
    parameter int GPR_WIDTH = 64
) (
    input logic          clk,
    input logic          rst,
    xu0_bcd_wbq_if.slave bus
);
    localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam int PW = $clog2(DEPTH);
    // One spare bit so count plus two in-flight tags never wraps.
    localparam int CW = $clog2(DEPTH + 1) + 1;

    // Tag pipe. ex3_iss_q remembers that an op reached EX3 even if it was
    // flushed on the way; the datapath does not see flushes and still raises
    // done, so that must not be reported as a protocol error.
    logic          ex2_val_q, ex3_val_q, ex3_iss_q;
    logic [TW-1:0] ex2_tid_q, ex3_tid_q;
    logic [5:0]    ex2_ta_q, ex3_ta_q;

    // Queue storage; entry valid bits are kept separately so a flush can kill
    // entries in place without disturbing the pointers.
    logic [TW-1:0]        q_tid_q  [DEPTH];
    logic [5:0]           q_ta_q   [DEPTH];
    logic [GPR_WIDTH-1:0] q_data_q [DEPTH];
    logic [DEPTH-1:0]     q_vld_q, q_vld_d;
    logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 err_q, err_d;

    logic          not_empty, full, head_vld, wr_val, push, push_ok, pop;
    logic [CW-1:0] occupancy;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign head_vld  = q_vld_q[head_q];
    assign wr_val    = not_empty & head_vld & ~bus.xu_ex_flush[q_tid_q[head_q]];
    // Dead (flushed) entries at the head retire without a write.
    assign pop       = (wr_val & bus.gpr_bcd_wr_gnt) | (not_empty & ~head_vld);
    assign push      = ex3_val_q & bus.bcd_byp_ex3_done & ~bus.xu_ex_flush[ex3_tid_q];
    // A push into a full queue with no pop is dropped (and flagged as an error).
    assign push_ok   = push & (~full | pop);
    // Reserve a slot for every live op still in EX2/EX3.
    assign occupancy = count_q + CW'(ex2_val_q) + CW'(ex3_val_q);

    assign bus.bcd_dec_stall = (occupancy >= CW'(DEPTH));
    assign bus.bcd_wr_val    = wr_val;
    assign bus.bcd_wr_tid    = not_empty ? q_tid_q[head_q]  : '0;
    assign bus.bcd_wr_ta     = not_empty ? q_ta_q[head_q]   : '0;
    assign bus.bcd_wr_data   = not_empty ? q_data_q[head_q] : '0;
    assign bus.bcd_wbq_err   = err_q;

    always_comb begin
        q_vld_d = q_vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.xu_ex_flush[q_tid_q[i]]) q_vld_d[i] = 1'b0;
        end
        if (pop) begin
            q_vld_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        // Push after pop: when full with a pop, tail==head and the new entry wins.
        if (push_ok) begin
            q_vld_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A done with no tag in EX3 has no thread to qualify it, so it is
        // always an error; a missing done is excused only if the tag's thread
        // is being flushed.
        err_d = err_q
              | (ex3_iss_q & ~bus.bcd_byp_ex3_done & ~bus.xu_ex_flush[ex3_tid_q])
              | (~ex3_iss_q & bus.bcd_byp_ex3_done)
              | (push & full & ~pop)
              | (bus.dec_bcd_ex1_val & bus.bcd_dec_stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex2_val_q <= 1'b0;
            ex3_val_q <= 1'b0;
            ex3_iss_q <= 1'b0;
            ex2_tid_q <= '0;
            ex3_tid_q <= '0;
            ex2_ta_q  <= '0;
            ex3_ta_q  <= '0;
            q_vld_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            ex2_val_q <= bus.dec_bcd_ex1_val;
            ex2_tid_q <= bus.dec_bcd_ex1_tid;
            ex2_ta_q  <= bus.dec_bcd_ex1_ta;
            ex3_iss_q <= ex2_val_q;
            ex3_val_q <= ex2_val_q & ~bus.xu_ex_flush[ex2_tid_q];
            ex3_tid_q <= ex2_tid_q;
            ex3_ta_q  <= ex2_ta_q;
            q_vld_q   <= q_vld_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    // Payload needs no reset: it is only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            q_tid_q[tail_q]  <= ex3_tid_q;
            q_ta_q[tail_q]   <= ex3_ta_q;
            q_data_q[tail_q] <= bus.bcd_byp_ex3_rt;
        end
    end
endmodule

// File: tb/tb_xu0_bcd_wbq.sv
module tb_xu0_bcd_wbq;
    localparam int THREADS = 2;
    localparam int DEPTH   = 4;
    localparam int W       = 64;
    localparam logic [63:0] K6 = 64'h6666_6666_6666_6666;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xu0_bcd_wbq_if #(.THREADS(THREADS), .GPR_WIDTH(W)) bus ();
    xu0_bcd_wbq #(.THREADS(THREADS), .DEPTH(DEPTH), .GPR_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: queue of results + two in-flight slots
    typedef struct { logic tid; logic [5:0] ta; logic [63:0] d; bit alive; } ent_t;
    typedef struct { bit iss; bit live; logic tid; logic [5:0] ta; logic [63:0] rt; } stg_t;
    ent_t        mq[$];
    stg_t        m_ex2, m_ex3;
    bit          m_err;
    bit          e_wr_val;
    logic [63:0] cur_rt;

    function automatic stg_t empty_stg();
        stg_t s;
        s.iss = 0; s.live = 0; s.tid = 0; s.ta = 0; s.rt = 0;
        return s;
    endfunction

    function automatic bit m_stall();
        return (mq.size() + int'(m_ex2.live) + int'(m_ex3.live)) >= DEPTH;
    endfunction

    // Mid-cycle: compare every output with what the model predicts.
    task automatic settle();
        logic [63:0] et, eta, ed;
        #4;
        e_wr_val = (mq.size() != 0) && mq[0].alive && !bus.xu_ex_flush[mq[0].tid];
        et = 0; eta = 0; ed = 0;
        if (mq.size() != 0) begin et = 64'(mq[0].tid); eta = 64'(mq[0].ta); ed = mq[0].d; end
        chk("m_wr_val", 64'(bus.bcd_wr_val), 64'(e_wr_val));
        chk("m_wr_tid", 64'(bus.bcd_wr_tid), et);
        chk("m_wr_ta",  64'(bus.bcd_wr_ta),  eta);
        chk("m_wr_data", bus.bcd_wr_data,    ed);
        chk("m_stall",  64'(bus.bcd_dec_stall), 64'(m_stall()));
        chk("m_err",    64'(bus.bcd_wbq_err), 64'(m_err));
    endtask

    // Clock edge: advance the model with the inputs of the cycle just ended.
    task automatic adv();
        bit dn, push, pop;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ex2 = empty_stg();
            m_ex3 = empty_stg();
            m_err = 0;
        end else begin
            dn   = bus.bcd_byp_ex3_done;
            push = m_ex3.live && dn && !bus.xu_ex_flush[m_ex3.tid];
            pop  = (e_wr_val && bus.gpr_bcd_wr_gnt) || (mq.size() != 0 && !mq[0].alive);
            if (m_ex3.iss && !dn && !bus.xu_ex_flush[m_ex3.tid]) m_err = 1;
            if (!m_ex3.iss && dn) m_err = 1;
            if (bus.dec_bcd_ex1_val && m_stall()) m_err = 1;
            if (push && mq.size() == DEPTH && !pop) m_err = 1;
            if (pop) void'(mq.pop_front());
            foreach (mq[i]) if (bus.xu_ex_flush[mq[i].tid]) mq[i].alive = 0;
            if (push && mq.size() < DEPTH)
                mq.push_back('{tid: m_ex3.tid, ta: m_ex3.ta, d: bus.bcd_byp_ex3_rt, alive: 1});
            m_ex3      = m_ex2;
            m_ex3.live = m_ex2.live && !bus.xu_ex_flush[m_ex2.tid];
            m_ex2.iss  = bus.dec_bcd_ex1_val;
            m_ex2.live = bus.dec_bcd_ex1_val;
            m_ex2.tid  = bus.dec_bcd_ex1_tid;
            m_ex2.ta   = bus.dec_bcd_ex1_ta;
            m_ex2.rt   = cur_rt;
        end
        #1;
    endtask

    // Drive one cycle of inputs; the BCD datapath answers every op reaching EX3.
    task automatic drv(input bit v, input logic t, input logic [5:0] ta,
                       input logic [1:0] fl, input bit g);
        cur_rt                = {$urandom, $urandom};
        bus.dec_bcd_ex1_val   = v;
        bus.dec_bcd_ex1_tid   = t;
        bus.dec_bcd_ex1_ta    = ta;
        bus.bcd_byp_ex3_done  = m_ex3.iss;
        bus.bcd_byp_ex3_rt    = m_ex3.iss ? m_ex3.rt : 64'h0;
        bus.xu_ex_flush       = fl;
        bus.gpr_bcd_wr_gnt    = g;
    endtask

    task automatic step(input bit v, input logic t, input logic [5:0] ta,
                        input logic [1:0] fl, input bit g);
        drv(v, t, ta, fl, g);
        settle();
        adv();
    endtask

    // ---------------- directed table
    typedef struct {
        bit r; bit v; logic t; logic [5:0] ta; bit dn; logic [63:0] rt; logic [1:0] fl; bit g;
        bit ewv; logic et; logic [5:0] eta; logic [63:0] ed; bit est; bit eer;
    } row_t;
    row_t tbl[19];

    function automatic row_t mk(bit r, bit v, logic t, logic [5:0] ta, bit dn, logic [63:0] rt,
                                logic [1:0] fl, bit g, bit ewv, logic et, logic [5:0] eta,
                                logic [63:0] ed, bit est, bit eer);
        row_t x;
        x.r = r; x.v = v; x.t = t; x.ta = ta; x.dn = dn; x.rt = rt; x.fl = fl; x.g = g;
        x.ewv = ewv; x.et = et; x.eta = eta; x.ed = ed; x.est = est; x.eer = eer;
        return x;
    endfunction

    initial begin
        //             r v t ta dn rt          fl g  ewv et eta ed  st er
        tbl[0]  = mk(0,0,0,0, 0,0,          0,0, 0,0,0, 0,  0,0); // reset state
        tbl[1]  = mk(0,1,1,5, 0,0,          0,0, 0,0,0, 0,  0,0); // issue tid1 ta5
        tbl[2]  = mk(0,0,0,0, 0,0,          0,0, 0,0,0, 0,  0,0);
        tbl[3]  = mk(0,0,0,0, 1,K6,         0,0, 0,0,0, 0,  0,0); // EX3 done, push
        tbl[4]  = mk(0,0,0,0, 0,0,          0,1, 1,1,5, K6, 0,0); // write at T+3
        tbl[5]  = mk(0,0,0,0, 0,0,          0,0, 0,0,0, 0,  0,0); // drained
        tbl[6]  = mk(0,1,0,7, 0,0,          0,0, 0,0,0, 0,  0,0); // issue tid0
        tbl[7]  = mk(0,0,0,0, 0,0,          1,0, 0,0,0, 0,  0,0); // flush in EX2
        tbl[8]  = mk(0,0,0,0, 1,64'h1234,   0,0, 0,0,0, 0,  0,0); // done, no push
        tbl[9]  = mk(0,0,0,0, 0,0,          0,1, 0,0,0, 0,  0,0); // no write, no err
        tbl[10] = mk(0,1,1,9, 0,0,          0,0, 0,0,0, 0,  0,0); // issue tid1
        tbl[11] = mk(0,0,0,0, 0,0,          0,0, 0,0,0, 0,  0,0);
        tbl[12] = mk(0,0,0,0, 1,64'hABC,    2,0, 0,0,0, 0,  0,0); // flush in EX3
        tbl[13] = mk(0,0,0,0, 0,0,          0,1, 0,0,0, 0,  0,0);
        tbl[14] = mk(0,0,0,0, 1,0,          0,0, 0,0,0, 0,  0,0); // done without tag
        tbl[15] = mk(0,0,0,0, 0,0,          0,0, 0,0,0, 0,  0,1); // error raised
        tbl[16] = mk(0,0,0,0, 0,0,          0,0, 0,0,0, 0,  0,1); // sticky
        tbl[17] = mk(1,0,0,0, 0,0,          0,0, 0,0,0, 0,  0,1);
        tbl[18] = mk(0,0,0,0, 0,0,          0,0, 0,0,0, 0,  0,0); // cleared by rst
    end

    initial begin
        m_ex2 = empty_stg();
        m_ex3 = empty_stg();
        m_err = 0;
        cur_rt = 0;
        rst = 1'b1;
        drv(0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- table-driven directed vectors
        for (int i = 0; i < 19; i++) begin
            rst                  = tbl[i].r;
            cur_rt               = 64'h0;
            bus.dec_bcd_ex1_val  = tbl[i].v;
            bus.dec_bcd_ex1_tid  = tbl[i].t;
            bus.dec_bcd_ex1_ta   = tbl[i].ta;
            bus.bcd_byp_ex3_done = tbl[i].dn;
            bus.bcd_byp_ex3_rt   = tbl[i].rt;
            bus.xu_ex_flush      = tbl[i].fl;
            bus.gpr_bcd_wr_gnt   = tbl[i].g;
            settle();
            chk($sformatf("tbl%0d_wr_val", i), 64'(bus.bcd_wr_val),    64'(tbl[i].ewv));
            chk($sformatf("tbl%0d_wr_tid", i), 64'(bus.bcd_wr_tid),    64'(tbl[i].et));
            chk($sformatf("tbl%0d_wr_ta", i),  64'(bus.bcd_wr_ta),     64'(tbl[i].eta));
            chk($sformatf("tbl%0d_data", i),   bus.bcd_wr_data,        tbl[i].ed);
            chk($sformatf("tbl%0d_stall", i),  64'(bus.bcd_dec_stall), 64'(tbl[i].est));
            chk($sformatf("tbl%0d_err", i),    64'(bus.bcd_wbq_err),   64'(tbl[i].eer));
            adv();
        end
        rst = 1'b0;

        // ---- backpressure: gnt low, issue until stall; exactly 4 ops fit
        for (int i = 0; i < 8; i++) begin
            drv(i < 4, i[0], 6'(10 + i), 0, 0);
            settle();
            chk($sformatf("bp_stall%0d", i), 64'(bus.bcd_dec_stall), 64'(i >= 4));
            adv();
        end
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 0, 0, 1);
            settle();
            chk($sformatf("bp_wr_val%0d", k), 64'(bus.bcd_wr_val), 64'd1);
            chk($sformatf("bp_wr_ta%0d", k),  64'(bus.bcd_wr_ta),  64'(10 + k));
            adv();
        end
        drv(0, 0, 0, 0, 1);
        settle();
        chk("bp_drained", 64'(bus.bcd_wr_val), 64'd0);
        adv();

        // ---- queue flush: tid0, tid1, tid0 queued; flush thread 0
        step(1, 0, 20, 0, 0);
        step(1, 1, 21, 0, 0);
        step(1, 0, 22, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        drv(0, 0, 0, 2'b01, 1);
        settle();
        chk("qf_head_drop", 64'(bus.bcd_wr_val), 64'd0);
        adv();
        drv(0, 0, 0, 0, 1);
        settle();
        chk("qf_dead_pop", 64'(bus.bcd_wr_val), 64'd0);
        adv();
        drv(0, 0, 0, 0, 1);
        settle();
        chk("qf_t1_val", 64'(bus.bcd_wr_val), 64'd1);
        chk("qf_t1_ta",  64'(bus.bcd_wr_ta),  64'd21);
        chk("qf_t1_tid", 64'(bus.bcd_wr_tid), 64'd1);
        adv();
        step(0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 1);
        settle();
        chk("qf_empty_val", 64'(bus.bcd_wr_val), 64'd0);
        chk("qf_empty_ta",  64'(bus.bcd_wr_ta),  64'd0);
        adv();

        // ---- run near full with simultaneous push/pop across pointer wrap
        for (int i = 0; i < 3; i++) step(1, i[0], 6'(30 + i), 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(!m_stall(), i[1], 6'(40 + i), 0, 1);

        // ---- reset mid-backlog
        for (int i = 0; i < 3; i++) step(1, i[0], 6'(50 + i), 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b1;
        step(0, 0, 0, 0, 1);
        rst = 1'b0;
        drv(0, 0, 0, 0, 1);
        settle();
        chk("rst_wr_val", 64'(bus.bcd_wr_val),    64'd0);
        chk("rst_stall",  64'(bus.bcd_dec_stall), 64'd0);
        chk("rst_data",   bus.bcd_wr_data,        64'd0);
        adv();

        // ---- randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 699) == 0);
            step(($urandom_range(0, 2) != 0) && !m_stall(), 1'($urandom),
                 6'($urandom), ($urandom_range(0, 11) == 0) ? 2'($urandom) : 2'b00,
                 $urandom_range(0, 3) != 0);
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
